// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue/writeback controller.
package alu_pkg;

    // ALU control codes
    localparam logic [4:0] CtrlNone = 5'h00;
    localparam logic [4:0] CtrlAdd  = 5'h02;
    localparam logic [4:0] CtrlSub  = 5'h03;
    localparam logic [4:0] CtrlAnd  = 5'h04;
    localparam logic [4:0] CtrlOr   = 5'h05;
    localparam logic [4:0] CtrlXor  = 5'h06;
    localparam logic [4:0] CtrlSll  = 5'h08;
    localparam logic [4:0] CtrlSrl  = 5'h09;
    localparam logic [4:0] CtrlNor  = 5'h0A;
    localparam logic [4:0] CtrlSubu = 5'h0B;
    localparam logic [4:0] CtrlAddu = 5'h0C;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;

    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational opcode/funct decode into ALU control code, operands and destination.
module alu_decode
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [REG_W-1:0]  rt,
    input  logic [REG_W-1:0]  rd,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic [4:0]        control,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic [REG_W-1:0]  dest,
    output logic              legal,
    output logic              is_signed_arith
);

    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] shamt_zext;

    assign imm_sext   = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zext   = {{(DATA_W-16){1'b0}}, imm};
    assign shamt_zext = {{(DATA_W-5){1'b0}}, shamt};

    always_comb begin
        control   = CtrlNone;
        operand_a = '0;
        operand_b = '0;
        dest      = '0;
        legal     = 1'b1;
        if (opcode == OpRtype) begin
            operand_a = rs_val;
            operand_b = rt_val;
            dest      = rd;
            unique case (funct)
                FnAdd:   control = CtrlAdd;
                FnAddu:  control = CtrlAddu;
                FnSub:   control = CtrlSub;
                FnSubu:  control = CtrlSubu;
                FnAnd:   control = CtrlAnd;
                FnOr:    control = CtrlOr;
                FnXor:   control = CtrlXor;
                FnNor:   control = CtrlNor;
                FnSll, FnSrl: begin
                    control   = (funct == FnSll) ? CtrlSll : CtrlSrl;
                    operand_a = rt_val;
                    operand_b = shamt_zext;
                end
                default: legal = 1'b0;
            endcase
        end else begin
            operand_a = rs_val;
            dest      = rt;
            unique case (opcode)
                OpAddi:  begin control = CtrlAdd;  operand_b = imm_sext; end
                OpAddiu: begin control = CtrlAddu; operand_b = imm_sext; end
                OpAndi:  begin control = CtrlAnd;  operand_b = imm_zext; end
                OpOri:   begin control = CtrlOr;   operand_b = imm_zext; end
                OpXori:  begin control = CtrlXor;  operand_b = imm_zext; end
                default: legal = 1'b0;
            endcase
        end
        // Illegal encodings still flow through the ALU, but with neutral inputs.
        if (!legal) begin
            control   = CtrlNone;
            operand_a = '0;
            operand_b = '0;
            dest      = '0;
        end
    end

    assign is_signed_arith = (control == CtrlAdd) || (control == CtrlSub);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller: accepts a decoded op, drives the registered ALU,
// and returns its result to the register file with zero/overflow status.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [5:0]        in_funct,
    input  logic [4:0]        in_shamt,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    input  logic [15:0]       in_imm,
    output logic [DATA_W-1:0] alu_operand_A,
    output logic [DATA_W-1:0] alu_operand_B,
    output logic [4:0]        alu_control,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic              alu_zero_in,
    output logic              wb_en,
    output logic [REG_W-1:0]  wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              zero_out,
    output logic              ovf_trap,
    output logic              illegal_op,
    output logic              done
);

    state_e            state;
    logic [REG_W-1:0]  dest_q;
    logic              legal_q;
    logic              signed_q;

    logic [4:0]        dec_control;
    logic [DATA_W-1:0] dec_a;
    logic [DATA_W-1:0] dec_b;
    logic [REG_W-1:0]  dec_dest;
    logic              dec_legal;
    logic              dec_signed;
    logic              ovf;
    logic              sign_a, sign_b, sign_r;

    alu_decode #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_decode (
        .opcode          (in_opcode),
        .funct           (in_funct),
        .shamt           (in_shamt),
        .imm             (in_imm),
        .rt              (in_rt),
        .rd              (in_rd),
        .rs_val          (in_rs_val),
        .rt_val          (in_rt_val),
        .control         (dec_control),
        .operand_a       (dec_a),
        .operand_b       (dec_b),
        .dest            (dec_dest),
        .legal           (dec_legal),
        .is_signed_arith (dec_signed)
    );

    assign in_ready = (state == StIdle);

    assign sign_a = alu_operand_A[DATA_W-1];
    assign sign_b = alu_operand_B[DATA_W-1];
    assign sign_r = alu_result_in[DATA_W-1];

    always_comb begin
        ovf = 1'b0;
        if (signed_q) begin
            if (alu_control == CtrlAdd) ovf = (sign_a == sign_b) && (sign_r != sign_a);
            else                        ovf = (sign_a != sign_b) && (sign_r != sign_a);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            alu_operand_A <= '0;
            alu_operand_B <= '0;
            alu_control   <= CtrlNone;
            dest_q        <= '0;
            legal_q       <= 1'b0;
            signed_q      <= 1'b0;
            wb_en         <= 1'b0;
            wb_addr       <= '0;
            wb_data       <= '0;
            zero_out      <= 1'b0;
            ovf_trap      <= 1'b0;
            illegal_op    <= 1'b0;
            done          <= 1'b0;
        end else begin
            // Completion outputs are single-cycle pulses.
            wb_en      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            zero_out   <= 1'b0;
            ovf_trap   <= 1'b0;
            illegal_op <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        alu_operand_A <= dec_a;
                        alu_operand_B <= dec_b;
                        alu_control   <= dec_control;
                        dest_q        <= dec_dest;
                        legal_q       <= dec_legal;
                        signed_q      <= dec_signed;
                        state         <= StExec;
                    end
                end
                StExec: state <= StWb;
                StWb: begin
                    done       <= 1'b1;
                    wb_en      <= legal_q && !ovf && (dest_q != '0);
                    wb_addr    <= dest_q;
                    wb_data    <= alu_result_in;
                    zero_out   <= alu_zero_in;
                    ovf_trap   <= ovf;
                    illegal_op <= !legal_q;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural registered ALU alongside.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode, in_funct;
    logic [4:0]  in_shamt, in_rt, in_rd;
    logic [31:0] in_rs_val, in_rt_val;
    logic [15:0] in_imm;
    logic [31:0] alu_operand_A, alu_operand_B;
    logic [4:0]  alu_control;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        wb_en, zero_out, ovf_trap, illegal_op, done;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_funct      (in_funct),
        .in_shamt      (in_shamt),
        .in_rt         (in_rt),
        .in_rd         (in_rd),
        .in_rs_val     (in_rs_val),
        .in_rt_val     (in_rt_val),
        .in_imm        (in_imm),
        .alu_operand_A (alu_operand_A),
        .alu_operand_B (alu_operand_B),
        .alu_control   (alu_control),
        .alu_result_in (alu_res),
        .alu_zero_in   (alu_zero),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .zero_out      (zero_out),
        .ovf_trap      (ovf_trap),
        .illegal_op    (illegal_op),
        .done          (done)
    );

    function automatic logic [31:0] alu_fn(input logic [4:0] c, input logic [31:0] a, b);
        case (c)
            5'h02, 5'h0C: return a + b;
            5'h03, 5'h0B: return a - b;
            5'h04:        return a & b;
            5'h05:        return a | b;
            5'h06:        return a ^ b;
            5'h0A:        return ~(a | b);
            5'h08:        return a << b[4:0];
            5'h09:        return a >> b[4:0];
            default:      return 32'h0;
        endcase
    endfunction

    // Registered ALU on the same clock and reset as the controller.
    always @(posedge clk or posedge reset) begin
        if (reset) alu_res <= 32'h0;
        else       alu_res <= alu_fn(alu_control, alu_operand_A, alu_operand_B);
    end
    assign alu_zero = (alu_res == 32'h0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction-level reference: what the ALU should see and what should be written back.
    task automatic ref_op(input logic [5:0] op, fn, input logic [4:0] sh, rt, rd,
                          input logic [31:0] rs_v, rt_v, input logic [15:0] imm,
                          output logic [4:0] ctrl, output logic [31:0] a, b, res,
                          output logic [4:0] dest, output logic legal, ovf);
        longint s;
        logic [31:0] se, ze;
        se = {{16{imm[15]}}, imm};
        ze = {16'h0, imm};
        s = 0; legal = 1'b1; ctrl = 5'h0; a = 0; b = 0; res = 0; dest = 0;
        if (op == 6'h00) begin
            a = rs_v; b = rt_v; dest = rd;
            case (fn)
                6'h20: begin ctrl = 5'h02; res = a + b;
                       s = longint'($signed(a)) + longint'($signed(b)); end
                6'h21: begin ctrl = 5'h0C; res = a + b; end
                6'h22: begin ctrl = 5'h03; res = a - b;
                       s = longint'($signed(a)) - longint'($signed(b)); end
                6'h23: begin ctrl = 5'h0B; res = a - b; end
                6'h24: begin ctrl = 5'h04; res = a & b; end
                6'h25: begin ctrl = 5'h05; res = a | b; end
                6'h26: begin ctrl = 5'h06; res = a ^ b; end
                6'h27: begin ctrl = 5'h0A; res = ~(a | b); end
                6'h00: begin ctrl = 5'h08; a = rt_v; b = {27'h0, sh}; res = rt_v << sh; end
                6'h02: begin ctrl = 5'h09; a = rt_v; b = {27'h0, sh}; res = rt_v >> sh; end
                default: legal = 1'b0;
            endcase
        end else begin
            a = rs_v; dest = rt;
            case (op)
                6'h08: begin ctrl = 5'h02; b = se; res = a + b;
                       s = longint'($signed(a)) + longint'($signed(b)); end
                6'h09: begin ctrl = 5'h0C; b = se; res = a + b; end
                6'h0C: begin ctrl = 5'h04; b = ze; res = a & b; end
                6'h0D: begin ctrl = 5'h05; b = ze; res = a | b; end
                6'h0E: begin ctrl = 5'h06; b = ze; res = a ^ b; end
                default: legal = 1'b0;
            endcase
        end
        if (!legal) begin ctrl = 0; a = 0; b = 0; res = 0; dest = 0; end
        ovf = (ctrl == 5'h02 || ctrl == 5'h03) &&
              (s > 64'sd2147483647 || s < -64'sd2147483648);
    endtask

    // One complete op through accept, EXEC, WB and the cycle after.
    task automatic do_op(input logic [5:0] op, fn, input logic [4:0] sh, rt, rd,
                         input logic [31:0] rs_v, rt_v, input logic [15:0] imm);
        logic [4:0] ctrl, dest;
        logic [31:0] a, b, res;
        logic legal, ovf;
        int n;
        ref_op(op, fn, sh, rt, rd, rs_v, rt_v, imm, ctrl, a, b, res, dest, legal, ovf);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 10) begin @(negedge clk); n++; end
        chk("ready_idle", {31'h0, in_ready}, 32'h1);
        in_opcode = op; in_funct = fn; in_shamt = sh; in_rt = rt; in_rd = rd;
        in_rs_val = rs_v; in_rt_val = rt_v; in_imm = imm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("alu_control", {27'h0, alu_control}, {27'h0, ctrl});
        chk("alu_operand_A", alu_operand_A, a);
        chk("alu_operand_B", alu_operand_B, b);
        chk("ready_busy", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        chk("done_early", {31'h0, done}, 32'h0);
        @(posedge clk); #1;
        chk("done", {31'h0, done}, 32'h1);
        chk("wb_en", {31'h0, wb_en}, {31'h0, legal && !ovf && dest != 0});
        if (legal) chk("wb_addr", {27'h0, wb_addr}, {27'h0, dest});
        chk("wb_data", wb_data, res);
        chk("zero_out", {31'h0, zero_out}, {31'h0, res == 0});
        chk("ovf_trap", {31'h0, ovf_trap}, {31'h0, ovf});
        chk("illegal_op", {31'h0, illegal_op}, {31'h0, !legal});
        @(posedge clk); #1;
        chk("done_pulse", {31'h0, done}, 32'h0);
        chk("wb_en_pulse", {31'h0, wb_en}, 32'h0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_A", alu_operand_A, 32'h0);
        chk("rst_B", alu_operand_B, 32'h0);
        chk("rst_ctrl", {27'h0, alu_control}, 32'h0);
        chk("rst_wb_en", {31'h0, wb_en}, 32'h0);
        chk("rst_wb_addr", {27'h0, wb_addr}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_flags", {28'h0, zero_out, ovf_trap, illegal_op, done}, 32'h0);
    endtask

    logic [5:0] ops [9];
    logic [5:0] fns [12];

    initial begin
        reset = 1'b1; in_valid = 1'b0;
        in_opcode = 0; in_funct = 0; in_shamt = 0; in_rt = 0; in_rd = 0;
        in_rs_val = 0; in_rt_val = 0; in_imm = 0;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;

        // Directed cases
        do_op(6'h08, 6'h00, 5'd0, 5'd5, 5'd0, 32'h10, 32'h0, 16'hFFFF);
        do_op(6'h00, 6'h20, 5'd0, 5'd0, 5'd3, 32'h7FFFFFFF, 32'h1, 16'h0);
        do_op(6'h00, 6'h21, 5'd0, 5'd0, 5'd3, 32'h7FFFFFFF, 32'h1, 16'h0);
        do_op(6'h00, 6'h00, 5'd4, 5'd0, 5'd7, 32'hDEAD, 32'h1, 16'h0);
        do_op(6'h00, 6'h22, 5'd0, 5'd0, 5'd0, 32'h55, 32'h55, 16'h0);
        do_op(6'h3F, 6'h20, 5'd3, 5'd9, 5'd9, 32'h1234, 32'h5678, 16'h1);
        do_op(6'h00, 6'h22, 5'd0, 5'd0, 5'd4, 32'h80000000, 32'h1, 16'h0);
        do_op(6'h0C, 6'h00, 5'd0, 5'd6, 5'd0, 32'hFFFFFFFF, 32'h0, 16'h8001);

        // Randomized ops against the reference
        ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23};
        fns = '{6'h00, 6'h02, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h01, 6'h2A};
        for (int i = 0; i < 40; i++) begin
            do_op(ops[$urandom_range(8)], fns[$urandom_range(11)], 5'($urandom),
                  5'($urandom), 5'($urandom), $urandom, $urandom, 16'($urandom));
        end

        // Back-to-back accepts with in_valid held, then reset during the second op's EXEC
        @(negedge clk);
        in_opcode = 6'h00; in_funct = 6'h20; in_rd = 5'd1; in_rs_val = 32'd3;
        in_rt_val = 32'd4; in_valid = 1'b1;
        chk("b2b_ready0", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        chk("b2b_A0", alu_operand_A, 32'd3);
        @(negedge clk); chk("b2b_ready1", {31'h0, in_ready}, 32'h0);
        @(negedge clk); chk("b2b_ready2", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        chk("b2b_done0", {31'h0, done}, 32'h1);
        chk("b2b_data0", wb_data, 32'd7);
        @(negedge clk);
        chk("b2b_ready3", {31'h0, in_ready}, 32'h1);
        in_funct = 6'h22; in_rd = 5'd2; in_rs_val = 32'd9;
        @(posedge clk); #1;
        chk("b2b_A1", alu_operand_A, 32'd9);
        chk("b2b_ctrl1", {27'h0, alu_control}, 32'h03);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_vals();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_done", {31'h0, done}, 32'h0);
            chk("abort_wb_en", {31'h0, wb_en}, 32'h0);
        end

        do_op(6'h0D, 6'h00, 5'd0, 5'd8, 5'd0, 32'hF0F00000, 32'h0, 16'h00FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
